// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, issues single-outstanding imem requests, and buffers words in a 2-entry queue.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        misalign_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_nxt;
  logic [31:0] r_req_pc;
  logic        r_kill;
  logic        w_kill_nxt;
  logic [31:0] r_q_pc   [2];
  logic [31:0] r_q_inst [2];
  logic        r_head;
  logic [1:0]  r_count;
  logic        r_misalign;

  logic        w_deq;
  logic [1:0]  w_occ_after;
  logic        w_issue;
  logic        w_enq;
  logic        w_tail;

  assign if_valid     = (r_count != 2'd0);
  assign if_pc        = r_q_pc[r_head];
  assign if_inst      = r_q_inst[r_head];
  assign imem_addr    = r_fetch_pc;
  assign misalign_err = r_misalign;

  // Issue is gated on the occupancy left after this cycle's dequeue, so the queue can never overflow.
  assign w_deq       = if_valid && !stall;
  assign w_occ_after = r_count - {1'b0, w_deq};
  assign w_issue     = imem_req && imem_gnt;
  assign w_enq       = (r_state == S_WAIT) && imem_rvalid && !r_kill && !redirect;
  assign w_tail      = r_head ^ r_count[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_fetch_pc <= RESET_VECTOR;
      r_kill     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_kill     <= w_kill_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_kill_nxt     = r_kill;
    imem_req       = 1'b0;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      S_BOOT: w_state_nxt = S_REQ;
      S_REQ: begin
        imem_req = (w_occ_after < 2'd2);
        if (imem_req && imem_gnt) begin
          w_state_nxt = S_WAIT;
          w_kill_nxt  = redirect;
        end
      end
      S_WAIT: begin
        // A response arriving together with a redirect is simply dropped; only a still-pending one needs killing.
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
          w_kill_nxt  = 1'b0;
        end else if (redirect) begin
          w_kill_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
    if (redirect) begin
      w_fetch_pc_nxt = redirect_pc & ~32'h3;
    end else if (w_issue) begin
      w_fetch_pc_nxt = r_fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_pc    <= '0;
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
      r_q_inst[0] <= '0;
      r_q_inst[1] <= '0;
      r_head      <= 1'b0;
      r_count     <= 2'd0;
      r_misalign  <= 1'b0;
    end else begin
      r_misalign <= redirect && (redirect_pc[1:0] != 2'b00);
      if (w_issue) begin
        r_req_pc <= r_fetch_pc;
      end
      if (redirect) begin
        r_head  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_enq) begin
          r_q_pc[w_tail]   <= r_req_pc;
          r_q_inst[w_tail] <= imem_rdata;
        end
        case ({w_enq, w_deq})
          2'b10: r_count <= r_count + 2'd1;
          2'b01: begin
            r_count <= r_count - 2'd1;
            r_head  <= ~r_head;
          end
          2'b11: r_head <= ~r_head;
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (w_enq) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (if_valid && stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a latency-programmable instruction memory model.
// Instruction words are modelled as address + 32'h1300_0000.
module tb_fetch_controller;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  logic        memValid;
  logic        forceRvalid;
  logic        memPending;
  int          memCount;
  int          memLatency;
  logic [31:0] memAddr;
  logic        sawGrant;
  logic [31:0] grantAddr;

  int checkCount;
  int errorCount;

  localparam logic [31:0] INST_OFFSET = 32'h1300_0000;

  assign imem_rvalid = memValid || forceRvalid;

  fetch_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .misalign_err (misalign_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: a grant seen at a posedge produces a one-cycle rvalid sampled memLatency edges later.
  initial begin
    memValid   = 1'b0;
    imem_rdata = '0;
    memPending = 1'b0;
    memCount   = 0;
    memAddr    = '0;
    forever begin
      @(posedge clk);
      sawGrant  = imem_req && imem_gnt;
      grantAddr = imem_addr;
      #1;
      memValid = 1'b0;
      if (sawGrant) begin
        memPending = 1'b1;
        memCount   = memLatency;
        memAddr    = grantAddr;
      end
      if (memPending) begin
        if (memCount <= 1) begin
          memValid   = 1'b1;
          imem_rdata = memAddr + INST_OFFSET;
          memPending = 1'b0;
        end else begin
          memCount = memCount - 1;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (actual !== expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs from a negedge and returns at the next negedge with redirect released.
  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic stl);
    redirect    = redir;
    redirect_pc = rpc;
    stall       = stl;
    @(negedge clk);
    redirect    = 1'b0;
    redirect_pc = '0;
    #1;
  endtask

  task automatic doReset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    forceRvalid = 1'b0;
    memLatency  = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checkCount  = 0;
    errorCount  = 0;
    rst_n       = 1'b0;
    imem_gnt    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    forceRvalid = 1'b0;
    memLatency  = 1;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_pc", if_pc, 32'h0);
    checkOutput("rst_inst", if_inst, 32'h0);
    checkOutput("rst_misalign", {31'd0, misalign_err}, 32'd0);

    // Sequential fetch with a 1-cycle memory
    $display("[TB] sequential fetch");
    doReset();
    checkOutput("boot_req", {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("first_req", {31'd0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("wait_req", {31'd0, imem_req}, 32'd0);
    checkOutput("wait_valid", {31'd0, if_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("seq0_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("seq0_pc", if_pc, 32'h0);
    checkOutput("seq0_inst", if_inst, 32'h1300_0000);
    checkOutput("seq1_addr", imem_addr, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("seq_gap_valid", {31'd0, if_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("seq1_pc", if_pc, 32'h4);
    checkOutput("seq1_inst", if_inst, 32'h1300_0004);
    checkOutput("seq2_addr", imem_addr, 32'h8);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("seq2_pc", if_pc, 32'h8);

    // Stall for 10 cycles from the first valid entry
    $display("[TB] stall fills queue");
    doReset();
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("stall_first_valid", {31'd0, if_valid}, 32'd1);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("full_req", {31'd0, imem_req}, 32'd0);
    checkOutput("full_pc", if_pc, 32'h0);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("full_hold_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("full_hold_pc", if_pc, 32'h0);
    checkOutput("full_hold_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    #1;
    checkOutput("unstall_req", {31'd0, imem_req}, 32'd1);
    checkOutput("unstall_addr", imem_addr, 32'h8);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("drain1_pc", if_pc, 32'h4);
    checkOutput("drain1_inst", if_inst, 32'h1300_0004);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("resume_pc", if_pc, 32'h8);
    checkOutput("resume_inst", if_inst, 32'h1300_0008);

    // Redirect coinciding with the grant for 0x8
    $display("[TB] redirect on grant");
    doReset();
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pre_redir_addr", imem_addr, 32'h8);
    checkOutput("pre_redir_valid", {31'd0, if_valid}, 32'd1);
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("redir_flush", {31'd0, if_valid}, 32'd0);
    checkOutput("redir_addr", imem_addr, 32'h100);
    checkOutput("redir_misalign", {31'd0, misalign_err}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("stale_dropped", {31'd0, if_valid}, 32'd0);
    checkOutput("redir_req", {31'd0, imem_req}, 32'd1);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("redir_pc", if_pc, 32'h100);
    checkOutput("redir_inst", if_inst, 32'h1300_0100);

    // Redirect while waiting; the response comes three cycles later
    $display("[TB] redirect in wait");
    memLatency = 4;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("slow_wait_req", {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b1, 32'h200, 1'b0);
    checkOutput("slow_redir_addr", imem_addr, 32'h200);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("slow_still_wait", {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("slow_discard_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("slow_next_req", {31'd0, imem_req}, 32'd1);
    checkOutput("slow_next_addr", imem_addr, 32'h200);
    memLatency = 1;
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("slow_pc", if_pc, 32'h200);
    checkOutput("slow_inst", if_inst, 32'h1300_0200);

    // Misaligned redirect target
    $display("[TB] misaligned redirect");
    applyStimulus(1'b1, 32'h0000_0103, 1'b0);
    checkOutput("misalign_pulse", {31'd0, misalign_err}, 32'd1);
    checkOutput("misalign_addr", imem_addr, 32'h100);
    checkOutput("misalign_flush", {31'd0, if_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("misalign_clear", {31'd0, misalign_err}, 32'd0);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("misalign_pc", if_pc, 32'h100);

    // Reset asserted mid-wait with responses arriving during reset and boot
    $display("[TB] reset during wait");
    memLatency = 3;
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("pre_rst_wait", {31'd0, imem_req}, 32'd0);
    rst_n       = 1'b0;
    forceRvalid = 1'b1;
    #1;
    checkOutput("mid_rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("mid_rst_addr", imem_addr, 32'h0);
    checkOutput("mid_rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("mid_rst_pc", if_pc, 32'h0);
    checkOutput("mid_rst_inst", if_inst, 32'h0);
    forceRvalid = 1'b0;
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("rst_rvalid_ignored", {31'd0, if_valid}, 32'd0);
    rst_n       = 1'b1;
    forceRvalid = 1'b1;
    memLatency  = 1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    forceRvalid = 1'b0;
    checkOutput("boot_rvalid_ignored", {31'd0, if_valid}, 32'd0);
    checkOutput("restart_req", {31'd0, imem_req}, 32'd1);
    checkOutput("restart_addr", imem_addr, 32'h0);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("restart_pc", if_pc, 32'h0);
    checkOutput("restart_inst", if_inst, 32'h1300_0000);

    // Fetch address wraps past the top of memory
    $display("[TB] address wrap");
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0);
    checkOutput("wrap_target", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("wrap_req", {31'd0, imem_req}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("wrap_next_addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("wrap_pc", if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_inst", if_inst, 32'h12FF_FFFC);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
